// File: rtl/rom_rd_master_if.sv
// Bus and stream signals of the ROM read master.
// The master modport is the initiator side; the slave modport is the
// responder/consumer side.
interface rom_rd_master_if;
    // Request/response memory bus
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        rsp_valid_i;
    logic        rsp_ready_o;
    logic [31:0] data_i;
    // Output word stream
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;

    modport master (
        output addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o,
        output out_data_o, out_valid_o, out_last_o,
        input  req_ready_i, rsp_valid_i, data_i, out_ready_i
    );

    modport slave (
        input  addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o,
        input  out_data_o, out_valid_o, out_last_o,
        output req_ready_i, rsp_valid_i, data_i, out_ready_i
    );
endinterface

// File: rtl/rom_rd_master.sv
// Sequential word reader: issues one 32-bit read at a time starting at a
// word-aligned base address and forwards each returned word on a
// valid/ready stream, flagging the final word.
module rom_rd_master #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    rom_rd_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        DONE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [31:0]      addr_reg;
    logic [LEN_W-1:0] rem_reg;
    logic [31:0]      data_reg;
    logic             last_reg;

    // The low address bits are deliberately discarded (word aligned reads).
    logic unused_addr_bits;
    assign unused_addr_bits = ^base_addr_i[1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a zero-length start goes straight to DONE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = (len_i != '0) ? REQ : DONE;
                end
            end
            REQ: begin
                if (bus.req_ready_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.rsp_valid_i) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready_i) begin
                    state_next = (rem_reg != '0) ? REQ : DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address/count latch on start; capture, count down and advance on response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg <= '0;
            rem_reg  <= '0;
            data_reg <= '0;
            last_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && start_i && len_i != '0) begin
                addr_reg <= {base_addr_i[31:2], 2'b00};
                rem_reg  <= len_i;
            end
            if (state_reg == WAIT && bus.rsp_valid_i) begin
                data_reg <= bus.data_i;
                last_reg <= (rem_reg == LEN_W'(1));
                rem_reg  <= rem_reg - LEN_W'(1);
                addr_reg <= addr_reg + 32'd4;
            end
        end
    end

    // Outputs decode directly from the state so each handshake line is
    // confined to its own state.
    assign busy_o          = (state_reg == REQ) || (state_reg == WAIT) || (state_reg == OUT);
    assign done_o          = (state_reg == DONE);
    assign bus.req_valid_o = (state_reg == REQ);
    assign bus.rsp_ready_o = (state_reg == WAIT);
    assign bus.out_valid_o = (state_reg == OUT);
    assign bus.addr_o      = addr_reg;
    assign bus.out_data_o  = data_reg;
    assign bus.out_last_o  = last_reg;
    assign bus.data_o      = 32'h0000_0000;
    assign bus.sel_o       = 4'hf;
    assign bus.we_o        = 1'b0;

endmodule

// File: tb/tb_rom_rd_master.sv
// Directed bench for rom_rd_master: plays the ROM responder and the stream
// consumer cycle by cycle, with hand-computed addresses and words.
module tb_rom_rd_master;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;

    rom_rd_master_if bus();

    rom_rd_master #(.LEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int req_cnt = 0;

    logic [31:0] ea [0:7];
    logic [31:0] ed [0:7];

    // Event counters for pulse and handshake accounting
    always @(posedge clk) begin
        if (done_o) done_cnt++;
        if (bus.req_valid_o && bus.req_ready_i) req_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ROM contents as seen by the responder
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic start_xfer(input logic [31:0] base, input logic [15:0] len);
        base_addr_i = base;
        len_i       = len;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    // One read: wait for the request, optionally stall it, answer one cycle
    // after acceptance, then take the word (optionally after a stall).
    task automatic do_word(input int idx, input bit last, input int req_stall,
                           input int out_stall, input bit first);
        int n;
        logic [31:0] a0;
        n = 0;
        while (bus.req_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_valid", 32'(bus.req_valid_o), 32'd1);
        if (!first) check("req_gap", 32'(n), 32'd0);
        check("req_addr", bus.addr_o, ea[idx]);
        check("rsp_ready_in_req", 32'(bus.rsp_ready_o), 32'd0);
        a0 = bus.addr_o;
        for (int i = 0; i < req_stall; i++) begin
            bus.rsp_valid_i = 1'b1;
            bus.data_i      = 32'hDEAD_BEEF;
            @(negedge clk);
            check("req_hold_valid", 32'(bus.req_valid_o), 32'd1);
            check("req_hold_addr", bus.addr_o, a0);
        end
        bus.rsp_valid_i = 1'b0;
        bus.req_ready_i = 1'b1;
        @(negedge clk);
        bus.req_ready_i = 1'b0;
        check("wait_rsp_ready", 32'(bus.rsp_ready_o), 32'd1);
        check("wait_no_req", 32'(bus.req_valid_o), 32'd0);
        bus.rsp_valid_i = 1'b1;
        bus.data_i      = rom_word(a0);
        @(negedge clk);
        bus.rsp_valid_i = 1'b0;
        bus.data_i      = 32'h0;
        check("out_valid", 32'(bus.out_valid_o), 32'd1);
        check("out_data", bus.out_data_o, ed[idx]);
        check("out_last", 32'(bus.out_last_o), 32'(last));
        check("rsp_ready_in_out", 32'(bus.rsp_ready_o), 32'd0);
        for (int i = 0; i < out_stall; i++) begin
            bus.rsp_valid_i = 1'b1;
            bus.data_i      = 32'h1234_5678;
            @(negedge clk);
            check("out_hold_valid", 32'(bus.out_valid_o), 32'd1);
            check("out_hold_data", bus.out_data_o, ed[idx]);
            check("out_stall_no_req", 32'(bus.req_valid_o), 32'd0);
        end
        bus.rsp_valid_i = 1'b0;
        bus.data_i      = 32'h0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        $display("word %0d addr=%h data=%h last=%0b", idx, a0, ed[idx], last);
    endtask

    // Expect the single done pulse right after the final stream handshake
    task automatic expect_done(input int done_before);
        check("done_pulse", 32'(done_o), 32'd1);
        check("done_busy_low", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("done_cleared", 32'(done_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("done_count", 32'(done_cnt), 32'(done_before + 1));
    endtask

    task automatic run(input logic [31:0] base, input int len, input int stall_idx,
                       input int req_stall, input int out_stall);
        int d0;
        d0 = done_cnt;
        start_xfer(base, 16'(len));
        check("busy_after_start", 32'(busy_o), 32'd1);
        for (int i = 0; i < len; i++) begin
            do_word(i, (i == len - 1), (i == stall_idx) ? req_stall : 0,
                    (i == stall_idx) ? out_stall : 0, (i == 0));
        end
        expect_done(d0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int r0;
        rst = 1'b1;
        start_i = 1'b0;
        base_addr_i = 32'h0;
        len_i = 16'h0;
        bus.req_ready_i = 1'b0;
        bus.rsp_valid_i = 1'b0;
        bus.data_i = 32'h0;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_req_valid", 32'(bus.req_valid_o), 32'd0);
        check("rst_addr", bus.addr_o, 32'h0);
        check("rst_sel", 32'(bus.sel_o), 32'hf);
        check("rst_we", 32'(bus.we_o), 32'd0);
        check("rst_wdata", bus.data_o, 32'h0);
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic four-word read
        ea[0] = 32'h0000_0100; ed[0] = 32'hC0DE_0100;
        ea[1] = 32'h0000_0104; ed[1] = 32'hC0DE_0104;
        ea[2] = 32'h0000_0108; ed[2] = 32'hC0DE_0108;
        ea[3] = 32'h0000_010C; ed[3] = 32'hC0DE_010C;
        r0 = req_cnt;
        run(32'h0000_0100, 4, -1, 0, 0);
        check("t1_req_count", 32'(req_cnt - r0), 32'd4);

        // 2: zero length
        r0 = req_cnt;
        d0 = done_cnt;
        start_xfer(32'h0000_0500, 16'd0);
        check("t2_no_req", 32'(bus.req_valid_o), 32'd0);
        check("t2_no_out", 32'(bus.out_valid_o), 32'd0);
        expect_done(d0);
        check("t2_req_count", 32'(req_cnt - r0), 32'd0);
        $display("len0 transfer done");

        // 3: request stalled 5 cycles; unaligned base; stray responses ignored
        ea[0] = 32'h0000_0040; ed[0] = 32'hC0DE_0040;
        r0 = req_cnt;
        run(32'h0000_0043, 1, 0, 5, 0);
        check("t3_req_count", 32'(req_cnt - r0), 32'd1);

        // 4: stream stall on the second of three words
        ea[0] = 32'h0000_1000; ed[0] = 32'hC0DE_1000;
        ea[1] = 32'h0000_1004; ed[1] = 32'hC0DE_1004;
        ea[2] = 32'h0000_1008; ed[2] = 32'hC0DE_1008;
        run(32'h0000_1000, 3, 1, 0, 3);

        // 5: address wrap
        ea[0] = 32'hFFFF_FFF8; ed[0] = 32'h3F21_FFF8;
        ea[1] = 32'hFFFF_FFFC; ed[1] = 32'h3F21_FFFC;
        ea[2] = 32'h0000_0000; ed[2] = 32'hC0DE_0000;
        run(32'hFFFF_FFF8, 3, -1, 0, 0);

        // 6: restart ignored while busy, then reset in WAIT
        ea[0] = 32'h0000_0200; ed[0] = 32'hC0DE_0200;
        d0 = done_cnt;
        start_xfer(32'h0000_0200, 16'd4);
        do_word(0, 1'b0, 0, 0, 1'b1);
        start_xfer(32'h0000_0800, 16'd1);
        check("t6_busy_held", 32'(busy_o), 32'd1);
        check("t6_addr_not_resampled", bus.addr_o, 32'h0000_0204);
        check("t6_req_valid", 32'(bus.req_valid_o), 32'd1);
        bus.req_ready_i = 1'b1;
        @(negedge clk);
        bus.req_ready_i = 1'b0;
        check("t6_in_wait", 32'(bus.rsp_ready_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_rsp_ready", 32'(bus.rsp_ready_o), 32'd0);
        check("t6_rst_out_data", bus.out_data_o, 32'h0);
        check("t6_rst_out_last", 32'(bus.out_last_o), 32'd0);
        check("t6_rst_addr", bus.addr_o, 32'h0);
        check("t6_rst_sel", 32'(bus.sel_o), 32'hf);
        bus.rsp_valid_i = 1'b1;
        bus.data_i = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.rsp_valid_i = 1'b0;
        bus.data_i = 32'h0;
        rst = 1'b0;
        @(negedge clk);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check("t6_no_out", 32'(bus.out_valid_o), 32'd0);
        $display("reset during transfer");

        // fresh transfer after reset
        ea[0] = 32'h0000_0300; ed[0] = 32'hC0DE_0300;
        ea[1] = 32'h0000_0304; ed[1] = 32'hC0DE_0304;
        run(32'h0000_0300, 2, -1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_rd_master.md
Name: rom_rd_master

Overview:
- Read initiator for the req/rsp valid-ready memory protocol served by the ROM/RAM peripherals (addr, data, sel, we, req_valid/req_ready, rsp_valid/rsp_ready).
- Given a base address and word count, it issues sequential 32-bit reads with one transaction outstanding.
- It forwards each returned word on a valid/ready output stream.
- Used for boot-time image copy and table loading from ROM.

Parameters:
- LEN_W, 16, width of the word-count input and the internal remaining-word counter.

Ports:
- clk  in  1  system clock; the single clock of the block
- rst  in  1  reset; asynchronous, active-high
- start_i  in  1  pulse; begins a transfer when idle
- base_addr_i  in  32  byte address of the first word; bits [1:0] ignored, treated as 0
- len_i  in  LEN_W  number of words to read
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle pulse when the transfer completes
- addr_o  out  32  bus request address
- data_o  out  32  bus write data; constant 0
- sel_o  out  4  byte select; constant 4'hf
- we_o  out  1  write enable; constant 0
- req_valid_o  out  1  request valid
- req_ready_i  in  1  request accepted by responder
- rsp_valid_i  in  1  response valid
- rsp_ready_o  out  1  master can take the response
- data_i  in  32  response read data, valid with rsp_valid_i
- out_data_o  out  32  streamed word
- out_valid_o  out  1  stream valid
- out_ready_i  in  1  stream consumer ready
- out_last_o  out  1  high with the final word of the transfer

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0 except sel_o = 4'hf. FSM goes to IDLE; counters and data register are cleared.
- FSM states: IDLE, REQ, WAIT, OUT, DONE.
- IDLE:
  - start_i=1 and len_i≠0: latch addr = {base_addr_i[31:2],2'b00} and rem = len_i; busy_o=1; go to REQ.
  - start_i=1 and len_i=0: go to DONE, with no bus activity.
- REQ: req_valid_o=1 and addr_o=addr. Hold both stable until req_ready_i. On handshake, go to WAIT.
- WAIT:
  - rsp_ready_o=1.
  - On rsp_valid_i: capture data_i into out_data_o, set out_last_o = (rem==1), decrement rem, add 4 to addr (32-bit wrap, 0xFFFF_FFFC → 0), go to OUT.
  - The response may arrive in the cycle after the request handshake (synchronous ROM) or later.
- OUT: out_valid_o=1 with data and last held stable until out_ready_i. On handshake:
  - rem≠0: go to REQ.
  - rem=0: go to DONE.
- DONE: done_o=1 for exactly one cycle; busy_o returns to 0 in that same cycle; go to IDLE.
- Single outstanding transaction:
  - req_valid_o is never high outside REQ.
  - rsp_ready_o is never high outside WAIT.
  - rsp_valid_i seen outside WAIT is ignored and not captured.
- Throughput: with an always-ready responder and consumer, 3 cycles per word. Stream backpressure stalls the next request.
- start_i while busy_o=1 is ignored. base_addr_i and len_i are not re-sampled.
- Mid-transfer reset: everything clears immediately. No done_o is produced and no partial word is emitted.
- len_i = all ones (65535 for LEN_W=16) is legal. The count must not overflow or wrap.

Test Plan:
1. base=0x0000_0100, len=4, responder answers 1 cycle after req, out_ready=1 → addr_o 0x100,0x104,0x108,0x10C; 4 stream words equal ROM contents; out_last_o only on 4th; done_o single pulse; busy_o low after.
2. len=0 start → done_o pulses in cycle 2 after start; req_valid_o never asserted; no stream output.
3. req_ready_i held low 5 cycles, then high → req_valid_o and addr_o stable all 5 cycles; exactly one request accepted.
4. out_ready_i low 3 cycles on word 2 of len=3 → out_data_o stable; no new request issued until the stream handshake.
5. base=0xFFFF_FFF8, len=3 → addr_o 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. start while busy mid-transfer, then async rst asserted in WAIT → second start ignored; on reset all outputs zero immediately; no done_o; a fresh start after reset runs normally.
